program_loader: RTL and testbench

Sequential writer for the instruction memory of the single-cycle core. Receives a byte stream over a valid/ready handshake and assembles it into little-endian instruction words. Writes those words to consecutive program-memory word addresses from 0 and holds the core stalled until the image is loaded and its checksum verified. Sits between the serial/debug byte source and the write port of a RAM-backed program memory. The core's fetch path is the reader on the other side.

---
 rtl/program_loader.sv | 158 +++++++++++++++
 tb/tb_program_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: loads the instruction image into program memory from a byte stream.
//
// Stream format: count byte N, then 4*N payload bytes (each word LSB first), then one
// checksum byte equal to the XOR of all payload bytes. Words go to consecutive word
// addresses starting at 0. The core is held in reset-like stall until the image is
// loaded and its checksum matches.
//
// Ports:
//   clk            - system clock, rising edge
//   reset          - asynchronous active-low reset
//   Start_i        - begin a load (honoured in IDLE, DONE, ERROR)
//   Byte_i         - stream byte
//   Byte_Valid_i   - Byte_i valid
//   Byte_Ready_o   - loader accepts a byte this cycle (decoded from state only)
//   Mem_Write_o    - one-cycle program-memory write strobe
//   Mem_Address_o  - word address being written
//   Mem_Data_o     - word being written
//   Cpu_Hold_o     - core must stall with PC at 0
//   Done_o         - image loaded, checksum good
//   Error_o        - bad word count or checksum mismatch
//   Words_Loaded_o - words written in the current load
module program_loader #(
  parameter int unsigned MEMORY_DEPTH = 64,
  parameter int unsigned DATA_WIDTH   = 32,
  localparam int unsigned AddrW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start_i,
  input  logic [7:0]            Byte_i,
  input  logic                  Byte_Valid_i,
  output logic                  Byte_Ready_o,
  output logic                  Mem_Write_o,
  output logic [AddrW-1:0]      Mem_Address_o,
  output logic [DATA_WIDTH-1:0] Mem_Data_o,
  output logic                  Cpu_Hold_o,
  output logic                  Done_o,
  output logic                  Error_o,
  output logic [8:0]            Words_Loaded_o
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StCount = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StWrite = 3'd3;
  localparam logic [2:0] StCheck = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;
  localparam logic [2:0] StError = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [7:0]            n_q, n_d;
  logic [1:0]            lane_q, lane_d;
  logic [23:0]           asm_q, asm_d;      // lanes 0..2 of the word being assembled
  logic [7:0]            xor_q, xor_d;
  logic [8:0]            words_q, words_d;  // also the address of the next word
  logic [AddrW-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic accept;

  // Handshake outputs depend on state only, never on Byte_Valid_i.
  always_comb begin
    Byte_Ready_o = (state_q == StCount) || (state_q == StData) || (state_q == StCheck);
    Mem_Write_o  = (state_q == StWrite);
    Cpu_Hold_o   = (state_q == StCount) || (state_q == StData) || (state_q == StWrite) ||
                   (state_q == StCheck) || (state_q == StError);
    Done_o       = (state_q == StDone);
    Error_o      = (state_q == StError);
  end

  assign accept         = Byte_Ready_o && Byte_Valid_i;
  assign Mem_Address_o  = addr_q;
  assign Mem_Data_o     = data_q;
  assign Words_Loaded_o = words_q;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    lane_d  = lane_q;
    asm_d   = asm_q;
    xor_d   = xor_q;
    words_d = words_q;
    addr_d  = addr_q;
    data_d  = data_q;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (Start_i) state_d = StCount;
      end

      StCount: begin
        if (accept) begin
          if (Byte_i == 8'd0 || {1'b0, Byte_i} > 9'(MEMORY_DEPTH)) begin
            state_d = StError;
          end else begin
            n_d     = Byte_i;
            lane_d  = 2'd0;
            xor_d   = 8'd0;
            words_d = 9'd0;
            state_d = StData;
          end
        end
      end

      StData: begin
        if (accept) begin
          xor_d  = xor_q ^ Byte_i;
          lane_d = lane_q + 2'd1;
          unique case (lane_q)
            2'd0: asm_d[7:0]   = Byte_i;
            2'd1: asm_d[15:8]  = Byte_i;
            2'd2: asm_d[23:16] = Byte_i;
            default: begin
              // Output registers change only here so they hold the last write elsewhere.
              data_d  = DATA_WIDTH'({Byte_i, asm_q});
              addr_d  = words_q[AddrW-1:0];
              state_d = StWrite;
            end
          endcase
        end
      end

      StWrite: begin
        words_d = words_q + 9'd1;
        state_d = (words_q + 9'd1 == {1'b0, n_q}) ? StCheck : StData;
      end

      StCheck: begin
        if (accept) state_d = (Byte_i == xor_q) ? StDone : StError;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      n_q     <= 8'd0;
      lane_q  <= 2'd0;
      asm_q   <= 24'd0;
      xor_q   <= 8'd0;
      words_q <= 9'd0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      xor_q   <= xor_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader (MEMORY_DEPTH=64). Inputs change 1 time unit after
// the rising edge; outputs are compared at that point.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Start_i = 1'b0;
  logic [7:0]  Byte_i = 8'd0;
  logic        Byte_Valid_i = 1'b0;
  logic        Byte_Ready_o;
  logic        Mem_Write_o;
  logic [5:0]  Mem_Address_o;
  logic [31:0] Mem_Data_o;
  logic        Cpu_Hold_o;
  logic        Done_o;
  logic        Error_o;
  logic [8:0]  Words_Loaded_o;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_count = 0;
  int cyc      = 0;
  logic [7:0] xs;

  program_loader #(
    .MEMORY_DEPTH(64),
    .DATA_WIDTH  (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .Start_i       (Start_i),
    .Byte_i        (Byte_i),
    .Byte_Valid_i  (Byte_Valid_i),
    .Byte_Ready_o  (Byte_Ready_o),
    .Mem_Write_o   (Mem_Write_o),
    .Mem_Address_o (Mem_Address_o),
    .Mem_Data_o    (Mem_Data_o),
    .Cpu_Hold_o    (Cpu_Hold_o),
    .Done_o        (Done_o),
    .Error_o       (Error_o),
    .Words_Loaded_o(Words_Loaded_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // The strobe spans a whole cycle, so the falling edge sees each write exactly once.
  always @(negedge clk) if (Mem_Write_o) wr_count <= wr_count + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_rdy"},   32'(Byte_Ready_o),   32'd0);
    check({tag, "_wr"},    32'(Mem_Write_o),    32'd0);
    check({tag, "_addr"},  32'(Mem_Address_o),  32'd0);
    check({tag, "_data"},  Mem_Data_o,          32'd0);
    check({tag, "_hold"},  32'(Cpu_Hold_o),     32'd0);
    check({tag, "_done"},  32'(Done_o),         32'd0);
    check({tag, "_err"},   32'(Error_o),        32'd0);
    check({tag, "_words"}, 32'(Words_Loaded_o), 32'd0);
  endtask

  task automatic do_start();
    Start_i = 1'b1;
    tick();
    Start_i = 1'b0;
    check("start_rdy",  32'(Byte_Ready_o), 32'd1);
    check("start_hold", 32'(Cpu_Hold_o),   32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    Byte_i = b;
    Byte_Valid_i = 1'b1;
    while (!Byte_Ready_o && n < 20) begin
      tick();
      n++;
    end
    if (!Byte_Ready_o) begin
      check("ready_timeout", 32'd0, 32'd1);
    end else begin
      tick();
    end
    Byte_Valid_i = 1'b0;
  endtask

  // Sends one word LSB first, then checks the write strobe in the following cycle.
  task automatic send_word(input logic [31:0] w, input int idx, input bit gap);
    for (int k = 0; k < 4; k++) begin
      if (gap) tick();
      send_byte(w[8*k +: 8]);
      xs = xs ^ w[8*k +: 8];
    end
    check("wr_strobe", 32'(Mem_Write_o),   32'd1);
    check("wr_rdy",    32'(Byte_Ready_o),  32'd0);
    check("wr_addr",   32'(Mem_Address_o), 32'(idx));
    check("wr_data",   Mem_Data_o,         w);
  endtask

  initial begin
    int c0, w0;

    // Reset state
    #12;
    check_idle_zero("reset");
    reset = 1'b1;
    tick();
    check_idle_zero("idle");

    // 1: two-word image at full rate, good checksum (0x13^0x05^0x93^0x05^0x10 = 0x90)
    do_start();
    c0 = cyc;
    w0 = wr_count;
    xs = 8'd0;
    send_byte(8'h02);
    send_word(32'h00000513, 0, 1'b0);
    send_word(32'h00100593, 1, 1'b0);
    check("t1_xs", 32'(xs), 32'h90);
    send_byte(xs);
    check("t1_done",   32'(Done_o),         32'd1);
    check("t1_err",    32'(Error_o),        32'd0);
    check("t1_hold",   32'(Cpu_Hold_o),     32'd0);
    check("t1_words",  32'(Words_Loaded_o), 32'd2);
    check("t1_cycles", 32'(cyc - c0),       32'd12);
    check("t1_nwr",    32'(wr_count - w0),  32'd2);
    check("t1_haddr",  32'(Mem_Address_o),  32'd1);
    check("t1_hdata",  Mem_Data_o,          32'h00100593);

    // 2: same image, wrong checksum; Start in DONE clears Done_o on the same edge
    do_start();
    check("t2_done_clr", 32'(Done_o), 32'd0);
    w0 = wr_count;
    xs = 8'd0;
    send_byte(8'h02);
    send_word(32'h00000513, 0, 1'b0);
    send_word(32'h00100593, 1, 1'b0);
    send_byte(8'h00);
    check("t2_err",  32'(Error_o),        32'd1);
    check("t2_hold", 32'(Cpu_Hold_o),     32'd1);
    check("t2_done", 32'(Done_o),         32'd0);
    check("t2_rdy",  32'(Byte_Ready_o),   32'd0);
    check("t2_nwr",  32'(wr_count - w0),  32'd2);

    // 3: count 0 and count 65 both error immediately with no write
    w0 = wr_count;
    do_start();
    check("t3_err_clr", 32'(Error_o), 32'd0);
    send_byte(8'h00);
    check("t3_err0", 32'(Error_o), 32'd1);
    do_start();
    send_byte(8'h41);
    check("t3_err41", 32'(Error_o), 32'd1);
    tick();
    check("t3_nwr", 32'(wr_count - w0), 32'd0);

    // 4: full 64-word image with Byte_Valid_i toggling every other cycle
    do_start();
    w0 = wr_count;
    xs = 8'd0;
    send_byte(8'h40);
    for (int i = 0; i < 64; i++) begin
      send_word({8'(i), 8'(i ^ 8'h5a), 8'(8'hc3 - i), 8'(i * 3)}, i, 1'b1);
    end
    tick();
    send_byte(xs);
    check("t4_done",  32'(Done_o),         32'd1);
    check("t4_words", 32'(Words_Loaded_o), 32'd64);
    check("t4_nwr",   32'(wr_count - w0),  32'd64);
    check("t4_addr",  32'(Mem_Address_o),  32'd63);

    // 5: reset mid-load after two of four words
    do_start();
    xs = 8'd0;
    send_byte(8'h04);
    send_word(32'hdeadbeef, 0, 1'b0);
    send_word(32'h12345678, 1, 1'b0);
    send_byte(8'haa);
    #2;
    reset = 1'b0;
    #1;
    check_idle_zero("t5_async");
    w0 = wr_count;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("t5_nwr", 32'(wr_count - w0), 32'd0);
    do_start();
    xs = 8'd0;
    send_byte(8'h01);
    send_word(32'hcafef00d, 0, 1'b0);
    send_byte(xs);
    check("t5_done",  32'(Done_o),         32'd1);
    check("t5_words", 32'(Words_Loaded_o), 32'd1);

    // 6: Start pulsed mid-word is ignored
    do_start();
    xs = 8'd0;
    send_byte(8'h02);
    send_word(32'h01020304, 0, 1'b0);
    send_byte(8'h11);
    xs = xs ^ 8'h11;
    Start_i = 1'b1;
    tick();
    Start_i = 1'b0;
    check("t6_rdy", 32'(Byte_Ready_o), 32'd1);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    xs = xs ^ 8'h22 ^ 8'h33 ^ 8'h44;
    check("t6_wr",   32'(Mem_Write_o), 32'd1);
    check("t6_data", Mem_Data_o,       32'h44332211);
    send_byte(xs);
    check("t6_done",  32'(Done_o),         32'd1);
    check("t6_words", 32'(Words_Loaded_o), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
